convergence_monitor: RTL and testbench
======================================

Name: convergence_monitor

Overview:
Parametrised k-means stop-criterion block; successor to the fixed 8-centre exact-match checker.
- Compares each new set of K cluster centres (x,y) against the previously accepted set.
- Declares convergence after STABLE_N consecutive update rounds where every centre moved by at most TOL per axis.
- Declares timeout when an iteration cap is reached.
- Sits between the centre-update datapath and the top-level k-means controller; the controller consumes done/converged/timeout.

Parameters:
- K, 8, number of cluster centres (1..64)
- WIDTH, 16, bits per coordinate, unsigned
- TOL, 0, max per-axis movement still counted as "not moved" (0 = exact match)
- STABLE_N, 1, consecutive stable rounds required for convergence (>=1)
- MAX_ITER, 255, update rounds after which timeout fires (>=2)
- ITER_W, 8, iteration counter width; must satisfy 2^ITER_W > MAX_ITER

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; begins a new run and clears all history
- updateCenters  in  1  one-cycle strobe; centres_x/centres_y hold a new valid set
- centres_x  in  K*WIDTH  packed x coords, centre i at [i*WIDTH +: WIDTH]
- centres_y  in  K*WIDTH  packed y coords, same packing
- done  out  1  run finished (converged or timeout); held until start
- converged  out  1  run ended by the stability criterion
- timeout  out  1  run ended by the iteration cap
- iter_count  out  ITER_W  update rounds accepted in the current run
- moved_mask  out  K  bit i = centre i exceeded TOL in the last compare

Behaviour:
- Reset (async, rst=1): state IDLE; done, converged, timeout, iter_count, moved_mask, stable_cnt and history registers all 0.
- All other logic is synchronous to the rising edge of clk.
- States: IDLE, PRIME, RUN, DONE.
- start in any state:
  - next state PRIME; clears iter_count, stable_cnt, moved_mask, done, converged, timeout.
  - Has priority over a simultaneous updateCenters, whose sample is discarded.
- IDLE: updateCenters ignored.
- PRIME, on updateCenters:
  - history <= inputs; iter_count <= 1; no comparison; moved_mask stays 0; next state RUN.
  - Avoids comparing the first set against zeroed history.
- RUN, on updateCenters:
  - Per centre i, per axis: d = |new - hist|, computed unsigned at WIDTH+1 bits. moved_i = (dx > TOL) || (dy > TOL).
  - moved_mask <= moved vector. history <= inputs. iter_count <= iter_count+1.
  - If no centre moved: stable_cnt <= stable_cnt+1. Otherwise stable_cnt <= 0.
  - If the incremented stable_cnt == STABLE_N: converged <= 1, done <= 1, next state DONE.
  - Else if the incremented iter_count == MAX_ITER: timeout <= 1, done <= 1, next state DONE.
  - If both conditions hold in the same round, converged wins and timeout stays 0.
- RUN without updateCenters: all registers hold.
- DONE:
  - Outputs and history hold.
  - updateCenters ignored, so iter_count does not advance.
  - Exits only on start or rst.
- Latency: outputs update on the clock edge that samples updateCenters; visible the following cycle. No combinational input-to-output path.
- Back-to-back updateCenters on consecutive cycles: each one is a full round.
- iter_count never wraps; MAX_ITER < 2^ITER_W is guaranteed by parameter rule and checked by an elaboration-time assertion.
- stable_cnt width: $clog2(STABLE_N+1).
- rst asserted mid-run: immediate return to IDLE with all values 0; a new start is required.

Decomposition:
- Shared package kmeans_pkg:
  - state enum {IDLE, PRIME, RUN, DONE}
  - coordinate width constant shared with the datapath
  - helper function for the stable_cnt width
- Sub-module centre_delta_cmp (params WIDTH, TOL):
  - inputs: new x/y, old x/y; output: moved.
  - Purely combinational abs-diff compare; instantiated K times in a generate loop.
- Top level holds the FSM, counters and the history registers.

Test Plan:
- Reset/prime, K=8, TOL=0: rst, start, one update with all x=10, y=20 -> iter_count=1, moved_mask=0, done=0.
- Exact convergence, TOL=0, STABLE_N=1: after prime, repeat identical set -> next cycle converged=1, done=1, iter_count=2, timeout=0.
- Tolerance, TOL=2, STABLE_N=2:
  - centre3 x moves 10->12, then 12->13: stable_cnt 1 then 2, converged after 3rd update.
  - Then centre5 y moves 20->23: moved_mask=8'h20 and stable_cnt cleared.
- Timeout, MAX_ITER=4: feed x=i+n on update n (always moving) -> done=1, timeout=1, converged=0 after 4th update; a 5th update leaves iter_count=4.
- Priority: same cycle as an update that would converge, assert start -> state PRIME, all flags 0, sample discarded. In a run reaching stable and MAX_ITER in one round -> converged=1, timeout=0.
- Async reset mid-run: pulse rst between clock edges in RUN with iter_count=3 -> outputs 0 immediately; updates ignored until start.

Source files
------------

// File: rtl/kmeans_pkg.sv
// Shared k-means definitions: monitor state encoding, coordinate width
// and the sizing helper for the stability counter.
package kmeans_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PRIME = 2'd1,
    RUN   = 2'd2,
    DONE  = 2'd3
  } mon_state_e;

  localparam int COORD_W = 16;

  // Bits needed to count 0..stable_n inclusive (at least one bit).
  function automatic int stable_cnt_w(input int stable_n);
    if (stable_n < 1) begin
      return 1;
    end else begin
      return $clog2(stable_n + 1);
    end
  endfunction

endpackage

// File: rtl/centre_delta_cmp.sv
// Per-centre movement detector: absolute per-axis difference against the
// previous centre, flagged when either axis moved further than TOL.
module centre_delta_cmp
  import kmeans_pkg::*;
#(
  parameter int WIDTH = COORD_W,
  parameter int TOL   = 0
) (
  input  logic [WIDTH-1:0] new_x,
  input  logic [WIDTH-1:0] new_y,
  input  logic [WIDTH-1:0] old_x,
  input  logic [WIDTH-1:0] old_y,
  output logic             moved
);

  localparam logic [WIDTH:0] TOL_V = (WIDTH+1)'(TOL);

  logic [WIDTH:0] dx_s;
  logic [WIDTH:0] dy_s;

  // Unsigned abs-diff on one extra bit so the subtraction never wraps.
  always_comb begin
    if (new_x >= old_x) begin
      dx_s = {1'b0, new_x} - {1'b0, old_x};
    end else begin
      dx_s = {1'b0, old_x} - {1'b0, new_x};
    end
    if (new_y >= old_y) begin
      dy_s = {1'b0, new_y} - {1'b0, old_y};
    end else begin
      dy_s = {1'b0, old_y} - {1'b0, new_y};
    end
    moved = (dx_s > TOL_V) || (dy_s > TOL_V);
  end

endmodule

// File: rtl/convergence_monitor_chk.sv
// Elaboration-time parameter legality checks for convergence_monitor.
module convergence_monitor_chk #(
  parameter int K        = 8,
  parameter int STABLE_N = 1,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) ();

  if (MAX_ITER >= (64'd1 << ITER_W)) begin : g_iter_w_bad
    $error("convergence_monitor: MAX_ITER must be below 2**ITER_W");
  end
  if (MAX_ITER < 2) begin : g_max_iter_bad
    $error("convergence_monitor: MAX_ITER must be at least 2");
  end
  if (STABLE_N < 1) begin : g_stable_bad
    $error("convergence_monitor: STABLE_N must be at least 1");
  end
  if ((K < 1) || (K > 64)) begin : g_k_bad
    $error("convergence_monitor: K must be in 1..64");
  end

endmodule

// File: rtl/convergence_monitor.sv
// k-means stop criterion: compares each new centre set with the previous
// one and reports convergence after STABLE_N quiet rounds or timeout at MAX_ITER.
module convergence_monitor
  import kmeans_pkg::*;
#(
  parameter int K        = 8,
  parameter int WIDTH    = COORD_W,
  parameter int TOL      = 0,
  parameter int STABLE_N = 1,
  parameter int MAX_ITER = 255,
  parameter int ITER_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               updateCenters,
  input  logic [K*WIDTH-1:0] centres_x,
  input  logic [K*WIDTH-1:0] centres_y,
  output logic               done,
  output logic               converged,
  output logic               timeout,
  output logic [ITER_W-1:0]  iter_count,
  output logic [K-1:0]       moved_mask
);

  localparam int                SC_W       = stable_cnt_w(STABLE_N);
  localparam logic [SC_W-1:0]   STABLE_TGT = SC_W'(STABLE_N);
  localparam logic [ITER_W-1:0] ITER_CAP   = ITER_W'(MAX_ITER);

  convergence_monitor_chk #(
    .K        (K),
    .STABLE_N (STABLE_N),
    .MAX_ITER (MAX_ITER),
    .ITER_W   (ITER_W)
  ) u_chk ();

  mon_state_e         state_r,  state_nxt_s;
  logic [ITER_W-1:0]  iter_r,   iter_nxt_s,   iter_inc_s;
  logic [SC_W-1:0]    stable_r, stable_nxt_s, stable_inc_s;
  logic [K-1:0]       mask_r,   mask_nxt_s;
  logic               done_r,   done_nxt_s;
  logic               conv_r,   conv_nxt_s;
  logic               tmo_r,    tmo_nxt_s;
  logic               hist_load_s;
  logic [K*WIDTH-1:0] hist_x_r;
  logic [K*WIDTH-1:0] hist_y_r;
  logic [K-1:0]       moved_s;
  logic               any_moved_s;

  for (genvar i = 0; i < K; i++) begin : g_cmp
    centre_delta_cmp #(
      .WIDTH (WIDTH),
      .TOL   (TOL)
    ) u_cmp (
      .new_x (centres_x[i*WIDTH +: WIDTH]),
      .new_y (centres_y[i*WIDTH +: WIDTH]),
      .old_x (hist_x_r[i*WIDTH +: WIDTH]),
      .old_y (hist_y_r[i*WIDTH +: WIDTH]),
      .moved (moved_s[i])
    );
  end

  assign any_moved_s  = |moved_s;
  assign iter_inc_s   = iter_r + ITER_W'(1);
  assign stable_inc_s = any_moved_s ? {SC_W{1'b0}} : (stable_r + SC_W'(1));

  // Next-state and next-output logic; start overrides any same-cycle update.
  always_comb begin
    state_nxt_s  = state_r;
    iter_nxt_s   = iter_r;
    stable_nxt_s = stable_r;
    mask_nxt_s   = mask_r;
    done_nxt_s   = done_r;
    conv_nxt_s   = conv_r;
    tmo_nxt_s    = tmo_r;
    hist_load_s  = 1'b0;
    if (start) begin
      state_nxt_s  = PRIME;
      iter_nxt_s   = {ITER_W{1'b0}};
      stable_nxt_s = {SC_W{1'b0}};
      mask_nxt_s   = {K{1'b0}};
      done_nxt_s   = 1'b0;
      conv_nxt_s   = 1'b0;
      tmo_nxt_s    = 1'b0;
    end else begin
      case (state_r)
        PRIME: begin
          // First set only seeds history; comparing against zeros is meaningless.
          if (updateCenters) begin
            hist_load_s = 1'b1;
            iter_nxt_s  = ITER_W'(1);
            state_nxt_s = RUN;
          end else begin
            state_nxt_s = PRIME;
          end
        end
        RUN: begin
          if (updateCenters) begin
            hist_load_s  = 1'b1;
            mask_nxt_s   = moved_s;
            iter_nxt_s   = iter_inc_s;
            stable_nxt_s = stable_inc_s;
            if (stable_inc_s == STABLE_TGT) begin
              conv_nxt_s  = 1'b1;
              done_nxt_s  = 1'b1;
              state_nxt_s = DONE;
            end else if (iter_inc_s == ITER_CAP) begin
              tmo_nxt_s   = 1'b1;
              done_nxt_s  = 1'b1;
              state_nxt_s = DONE;
            end else begin
              state_nxt_s = RUN;
            end
          end else begin
            state_nxt_s = RUN;
          end
        end
        IDLE, DONE: begin
          state_nxt_s = state_r;
        end
        default: begin
          state_nxt_s = IDLE;
        end
      endcase
    end
  end

  // State, counters, flags and centre history registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r  <= IDLE;
      iter_r   <= {ITER_W{1'b0}};
      stable_r <= {SC_W{1'b0}};
      mask_r   <= {K{1'b0}};
      done_r   <= 1'b0;
      conv_r   <= 1'b0;
      tmo_r    <= 1'b0;
      hist_x_r <= {(K*WIDTH){1'b0}};
      hist_y_r <= {(K*WIDTH){1'b0}};
    end else begin
      state_r  <= state_nxt_s;
      iter_r   <= iter_nxt_s;
      stable_r <= stable_nxt_s;
      mask_r   <= mask_nxt_s;
      done_r   <= done_nxt_s;
      conv_r   <= conv_nxt_s;
      tmo_r    <= tmo_nxt_s;
      if (hist_load_s) begin
        hist_x_r <= centres_x;
        hist_y_r <= centres_y;
      end else begin
        hist_x_r <= hist_x_r;
        hist_y_r <= hist_y_r;
      end
    end
  end

  assign done       = done_r;
  assign converged  = conv_r;
  assign timeout    = tmo_r;
  assign iter_count = iter_r;
  assign moved_mask = mask_r;

endmodule

// File: tb/tb_convergence_monitor.sv
// Scoreboard bench: two monitor configurations share one stimulus stream,
// each checked every cycle against a behavioural model of the stop rules.
module tb_convergence_monitor;

  localparam int K = 8;
  localparam int W = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           start = 1'b0;
  logic           upd = 1'b0;
  logic [K*W-1:0] cx = '0;
  logic [K*W-1:0] cy = '0;

  logic       done_a, conv_a, tmo_a;
  logic [2:0] iter_a;
  logic [K-1:0] mask_a;
  logic       done_b, conv_b, tmo_b;
  logic [4:0] iter_b;
  logic [K-1:0] mask_b;

  always #5 clk = ~clk;

  // A: exact match, one quiet round, cap of 4 rounds.
  convergence_monitor #(.K(K), .WIDTH(W), .TOL(0), .STABLE_N(1), .MAX_ITER(4), .ITER_W(3)) dut_a (
    .clk(clk), .rst(rst), .start(start), .updateCenters(upd),
    .centres_x(cx), .centres_y(cy), .done(done_a), .converged(conv_a),
    .timeout(tmo_a), .iter_count(iter_a), .moved_mask(mask_a));

  // B: tolerance 2, two quiet rounds, cap of 20 rounds.
  convergence_monitor #(.K(K), .WIDTH(W), .TOL(2), .STABLE_N(2), .MAX_ITER(20), .ITER_W(5)) dut_b (
    .clk(clk), .rst(rst), .start(start), .updateCenters(upd),
    .centres_x(cx), .centres_y(cy), .done(done_b), .converged(conv_b),
    .timeout(tmo_b), .iter_count(iter_b), .moved_mask(mask_b));

  typedef struct packed {
    logic       done;
    logic       conv;
    logic       tmo;
    logic [7:0] iter;
    logic [7:0] mask;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  int   n_vec = 0;
  int   n_err = 0;

  int cur_x[K];
  int cur_y[K];

  // Model: phase 0 = no run, 1 = awaiting first set, 2 = comparing, 3 = finished.
  int       p_tol[2] = '{0, 2};
  int       p_sn[2]  = '{1, 2};
  int       p_mi[2]  = '{4, 20};
  int       m_phase[2];
  int       m_iter[2];
  int       m_stable[2];
  bit       m_done[2];
  bit       m_conv[2];
  bit       m_tmo[2];
  logic [7:0] m_mask[2];
  int       m_hx[2][K];
  int       m_hy[2][K];

  function automatic void model_step(int u, bit r, bit st, bit up);
    logic [7:0] mk;
    int dx;
    int dy;
    mk = 8'h00;
    if (r) begin
      m_phase[u] = 0; m_iter[u] = 0; m_stable[u] = 0; m_mask[u] = 8'h00;
      m_done[u] = 1'b0; m_conv[u] = 1'b0; m_tmo[u] = 1'b0;
      for (int i = 0; i < K; i++) begin m_hx[u][i] = 0; m_hy[u][i] = 0; end
    end else if (st) begin
      m_phase[u] = 1; m_iter[u] = 0; m_stable[u] = 0; m_mask[u] = 8'h00;
      m_done[u] = 1'b0; m_conv[u] = 1'b0; m_tmo[u] = 1'b0;
    end else if (up && m_phase[u] == 1) begin
      for (int i = 0; i < K; i++) begin m_hx[u][i] = cur_x[i]; m_hy[u][i] = cur_y[i]; end
      m_iter[u] = 1;
      m_phase[u] = 2;
    end else if (up && m_phase[u] == 2) begin
      for (int i = 0; i < K; i++) begin
        dx = cur_x[i] - m_hx[u][i];
        dy = cur_y[i] - m_hy[u][i];
        if (dx < 0) dx = -dx;
        if (dy < 0) dy = -dy;
        if (dx > p_tol[u] || dy > p_tol[u]) mk[i] = 1'b1;
        m_hx[u][i] = cur_x[i];
        m_hy[u][i] = cur_y[i];
      end
      m_mask[u] = mk;
      m_iter[u] = m_iter[u] + 1;
      m_stable[u] = (mk == 8'h00) ? m_stable[u] + 1 : 0;
      if (m_stable[u] == p_sn[u]) begin
        m_conv[u] = 1'b1; m_done[u] = 1'b1; m_phase[u] = 3;
      end else if (m_iter[u] == p_mi[u]) begin
        m_tmo[u] = 1'b1; m_done[u] = 1'b1; m_phase[u] = 3;
      end
    end
  endfunction

  function automatic exp_t snap(int u);
    exp_t e;
    e.done = m_done[u];
    e.conv = m_conv[u];
    e.tmo  = m_tmo[u];
    e.iter = 8'(m_iter[u]);
    e.mask = m_mask[u];
    return e;
  endfunction

  function automatic exp_t act_a();
    exp_t e;
    e.done = done_a; e.conv = conv_a; e.tmo = tmo_a;
    e.iter = {5'd0, iter_a}; e.mask = mask_a;
    return e;
  endfunction

  function automatic exp_t act_b();
    exp_t e;
    e.done = done_b; e.conv = conv_b; e.tmo = tmo_b;
    e.iter = {3'd0, iter_b}; e.mask = mask_b;
    return e;
  endfunction

  task automatic check(string nm, exp_t act, exp_t exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got done=%0b conv=%0b tmo=%0b iter=%0d mask=%h, expected done=%0b conv=%0b tmo=%0b iter=%0d mask=%h",
               nm, $time, act.done, act.conv, act.tmo, act.iter, act.mask,
               exp.done, exp.conv, exp.tmo, exp.iter, exp.mask);
    end
  endtask

  task automatic pack_inputs();
    for (int i = 0; i < K; i++) begin
      cx[i*W +: W] = cur_x[i][W-1:0];
      cy[i*W +: W] = cur_y[i][W-1:0];
    end
  endtask

  // One cycle of stimulus; the expected post-edge outputs go to the scoreboard.
  task automatic drive(bit r, bit st, bit up);
    @(posedge clk);
    #2;
    rst = r; start = st; upd = up;
    pack_inputs();
    model_step(0, r, st, up);
    model_step(1, r, st, up);
    q_a.push_back(snap(0));
    q_b.push_back(snap(1));
  endtask

  // Reset pulse between edges: outputs must clear before the next edge.
  task automatic rst_pulse();
    @(posedge clk);
    #2;
    rst = 1'b1; start = 1'b0; upd = 1'b0;
    model_step(0, 1'b1, 1'b0, 1'b0);
    model_step(1, 1'b1, 1'b0, 1'b0);
    #1;
    check("async_rst_a", act_a(), snap(0));
    check("async_rst_b", act_b(), snap(1));
    #1;
    rst = 1'b0; upd = 1'b1;
    model_step(0, 1'b0, 1'b0, 1'b1);
    model_step(1, 1'b0, 1'b0, 1'b1);
    q_a.push_back(snap(0));
    q_b.push_back(snap(1));
  endtask

  task automatic set_all(int bx, int by);
    for (int i = 0; i < K; i++) begin cur_x[i] = bx; cur_y[i] = by; end
  endtask

  // Monitor: pops one expectation per cycle and compares it to the DUT.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q_a.size() > 0) begin e = q_a.pop_front(); check("dut_a", act_a(), e); end
      if (q_b.size() > 0) begin e = q_b.pop_front(); check("dut_b", act_b(), e); end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int sel;
    int c;
    set_all(0, 0);
    model_step(0, 1'b1, 1'b0, 1'b0);
    model_step(1, 1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);

    // Prime then exact repeat; an update in IDLE is ignored first.
    set_all(10, 20);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);

    // Tolerance: centre 3 x drifts 10->12->13, then a repeat.
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    cur_x[3] = 12; drive(1'b0, 1'b0, 1'b1);
    cur_x[3] = 13; drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // Centre 5 y jumps by 3, then two quiet rounds.
    set_all(10, 20);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    cur_y[5] = 23; drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    // Timeout: every centre moves each round; fifth update after the cap.
    drive(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 5; n++) begin
      for (int i = 0; i < K; i++) begin cur_x[i] = i + n; cur_y[i] = 7; end
      drive(1'b0, 1'b0, 1'b1);
    end

    // Priority: start with a converging update discards the sample.
    set_all(10, 20);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    cur_x[0] = 99; drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b0, 1'b1);

    // Async reset mid-run with three rounds accepted.
    drive(1'b0, 1'b1, 1'b0);
    for (int n = 1; n <= 3; n++) begin
      for (int i = 0; i < K; i++) begin cur_x[i] = i + n * 5; end
      drive(1'b0, 1'b0, 1'b1);
    end
    rst_pulse();
    drive(1'b0, 1'b0, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b0, 1'b1);

    // Random rounds: small moves straddle the tolerance, occasional restarts.
    set_all(100, 100);
    for (c = 0; c < 400; c++) begin
      if ($urandom_range(0, 1) == 0) begin
        sel = $urandom_range(0, K - 1);
        if ($urandom_range(0, 1) == 0) begin
          cur_x[sel] = cur_x[sel] + $urandom_range(0, 4);
        end else begin
          cur_y[sel] = cur_y[sel] - $urandom_range(0, 4);
        end
      end
      drive(1'b0, $urandom_range(0, 29) == 0, $urandom_range(0, 2) != 0);
    end

    drive(1'b0, 1'b0, 1'b0);
    drive(1'b0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #2;
    n_vec++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d/%0d pending expectations, expected 0/0", q_a.size(), q_b.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
